// File: rtl/uart_pkg.sv
// Shared UART definitions: data/entry widths, default RX FIFO depth and the
// layout of a receive FIFO entry ({ferr, data}).
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_ENTRY_W        = 9;
    localparam int UART_RX_FIFO_DEPTH  = 16;
    localparam int UART_ENTRY_DATA_LSB = 0;
    localparam int UART_ENTRY_FERR_BIT = 8;

    typedef struct packed {
        logic                   ferr;
        logic [UART_DATA_W-1:0] data;
    } uart_entry_t;

    function automatic uart_entry_t uart_make_entry(input logic ferr,
                                                    input logic [UART_DATA_W-1:0] data);
        uart_entry_t e;
        e.ferr = ferr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock show-ahead FIFO with explicit level counter; shared by
// the RX and TX paths. Full/empty come from the level, not pointer equality.
module uart_sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == DEPTH[AW:0]);
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the CPU register block.
// Optional interrupt logic is built only when UART_RX_IRQ_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_ready,
    input  logic                   framing_error,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_ferr,
    output logic                   rd_valid,
    output logic [AW:0]            level,
    output logic                   overflow,
    input  logic                   clr_overflow,
    input  logic                   irq_en,
    input  logic [AW:0]            irq_thresh,
    output logic                   irq
);

    logic        rdy_q;
    logic        overflow_q, overflow_d;
    logic        push;
    logic        pop;
    logic        drop;
    logic        fifo_full;
    logic        fifo_empty;
    uart_entry_t wr_entry;
    uart_entry_t head_entry;

    // rx_ready is a multi-cycle strobe; only its rising edge is a new byte.
    assign push     = rx_ready & ~rdy_q;
    assign pop      = rd_en & ~fifo_empty;
    assign drop     = push & fifo_full & ~pop;
    assign wr_entry = uart_make_entry(framing_error, rx_data);

    uart_sync_fifo #(
        .WIDTH (UART_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_empty ? '0 : head_entry.data;
    assign rd_ferr  = fifo_empty ? 1'b0 : head_entry.ferr;
    assign overflow = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rdy_q      <= rx_ready;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_RX_IRQ_EN
    logic irq_q, irq_d;

    // Threshold of zero disables the level source; overflow still interrupts.
    assign irq_d = irq_en & (((irq_thresh != '0) & (level >= irq_thresh)) | overflow_q);
    assign irq   = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`else
    logic irq_unused;

    assign irq_unused = irq_en ^ (^irq_thresh);
    assign irq        = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver in the SoC UART peripheral. It captures each completed byte and its framing-error flag when the receiver's ready strobe rises. It queues them in a show-ahead FIFO and presents them to the CPU-facing register interface with level, overflow and optional interrupt status. It decouples byte arrival (one byte per 10 bit-times) from software read latency.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, ≥ 2.
- `AW`, derived = log2(DEPTH) — pointer width; `level` is AW+1 bits.
- `clk`  in  1  — system clock; the same clock that drives the receiver.
- `reset`  in  1  — synchronous, active-high; the same net that resets the receiver.
- `rx_data`  in  8  — byte from the receiver; stable while `rx_ready` is high.
- `rx_ready`  in  1  — receiver done strobe; high for a full oversample-tick period, so it spans multiple `clk` cycles.
- `framing_error`  in  1  — stop-bit error for the byte; valid while `rx_ready` is high.
- `rd_en`  in  1  — pop the head entry.
- `rd_data`  out  8  — head byte (show-ahead); 0 when empty.
- `rd_ferr`  out  1  — framing flag of the head entry; 0 when empty.
- `rd_valid`  out  1  — FIFO not empty.
- `level`  out  AW+1  — number of stored entries, 0..DEPTH.
- `overflow`  out  1  — sticky: a byte was dropped because the FIFO was full.
- `clr_overflow`  in  1  — clears `overflow`.
- `irq_en`  in  1  — interrupt enable; used only with `UART_RX_IRQ_EN`.
- `irq_thresh`  in  AW+1  — level threshold; used only with `UART_RX_IRQ_EN`.
- `irq`  out  1  — interrupt request; used only with `UART_RX_IRQ_EN`.

## Operation
- Edge detect: `rdy_q` registers `rx_ready`. A push occurs in a cycle where `rx_ready & ~rdy_q`. Exactly one push per strobe, however many cycles it lasts.
- Entry = {framing_error, rx_data}, 9 bits, sampled in the push cycle.
- Pop: `rd_en & rd_valid` advances the read pointer. `rd_en` when empty is ignored, with no underflow flag.
- Push when not full: write at the write pointer, advance it, level +1.
- Push when full, no pop: the byte is dropped and `overflow` is set. Storage, pointers and level are unchanged.
- Push and pop in the same cycle, any level including full: both are performed, level is unchanged, no overflow.
- Pointers wrap modulo DEPTH. Full/empty are derived from `level` (DEPTH vs 0), not from pointer equality.
- `overflow`: set has priority over `clr_overflow` in the same cycle. Otherwise `clr_overflow` clears it next cycle.
- Reset values: pointers 0, `level` 0, `rd_valid` 0, `rd_data` 0, `rd_ferr` 0, `overflow` 0, `irq` 0, `rdy_q` 0.
- Reset mid-operation: contents are discarded. A `rx_ready` still high after reset deasserts is treated as a new rising edge and causes one push.

## Timing
- Push edge at cycle N: the entry is visible on `rd_data`/`rd_ferr`, and `rd_valid`/`level` update, at cycle N+1.
- Pop at cycle N: the next head, or 0 with `rd_valid`=0, appears at N+1. `level` updates at N+1.
- `overflow` rises the cycle after the dropped push.
- `irq` is registered and updates one cycle after `level`/`overflow` change.
- Throughput: one push and one pop per cycle max. Input strobes are far slower than this.

## Configuration
- `UART_RX_IRQ_EN` defined: `irq` = registered (`irq_en` & ((`irq_thresh` != 0 & `level` >= `irq_thresh`) | `overflow`)).
- `UART_RX_IRQ_EN` undefined: `irq` is tied 0, `irq_en` and `irq_thresh` are ignored, and no irq logic is synthesized. Port list is identical in both builds.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W` = 8, `UART_ENTRY_W` = 9, default `UART_RX_FIFO_DEPTH` = 16, entry field offsets (ferr = bit 8).
- Sub-module `uart_sync_fifo`: generic single-clock storage with pointers and level, parameterized on width and depth. The TX side reuses it.
- The top holds the edge detect, overflow logic, empty-output zeroing and irq.

## Test plan
- Reset, then one strobe with `rx_data`=0xA5, `framing_error`=0, held 16 cycles → exactly one push. Next cycle `rd_valid`=1, `rd_data`=0xA5, `level`=1. `rd_en` → `level`=0, `rd_data`=0.
- Strobe with 0x3C and `framing_error`=1 → `rd_ferr`=1 with `rd_data`=0x3C.
- 17 strobes into DEPTH=16, no reads → `level`=16 and `overflow`=1. Reads return bytes 1..16 in order; byte 17 is absent.
- At `level`=16, push 0x77 with `rd_en` in the same cycle → `level` stays 16, `overflow` stays 0, 0x77 is read last after wrap.
- `rd_en` on empty FIFO → `level` stays 0, no state change. `clr_overflow` in the same cycle as a new drop → `overflow` remains 1.
- With `UART_RX_IRQ_EN`, `irq_en`=1, `irq_thresh`=4: 3 pushes → `irq`=0; 4th push → `irq`=1 one cycle after `level`=4. Pop one → `irq`=0. Without the macro, `irq` stays 0 throughout.
